multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM plus ALU/immediate decoders for the multicycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the mux selects and write enables around the ALU, the ALU result register, instruction register, PC and register file.
- The ALU result register loads every cycle; this block selects when its contents are consumed (result_src = 00).

Parameters:
- SUPPORT_BNE, 1: when 1, branch funct3 001 is taken on !zero; when 0, every branch is treated as beq.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- op  in  7  instr[6:0], valid from DECODE onward
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, same cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  0 = PC, 1 = ALU result register as memory address
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction / old-PC register load
- reg_write  out  1  register-file write enable
- result_src  out  2  00 = ALU result register, 01 = memory data, 10 = live ALU result
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 data
- alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J

Behaviour:
- Reset is asynchronous and active-high (rst); the block is clocked on clk.
- On reset, state = FETCH.
- While rst is high, pc_write, ir_write, mem_write and reg_write are forced to 0.
- All other outputs are combinational from state and inputs.
- Moore outputs from state, except:
  - pc_write depends on zero in the BRANCH state.
  - alu_control depends on funct3/funct7b5/op.
- Any select not listed for a state is 00; any enable not listed is 0.

State outputs and transitions:
- FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=00, result_src=10, pc_update=1. Next: DECODE.
- DECODE: src_a=01, src_b=01, alu_op=00 (branch target into the ALU result register). Next by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> FETCH (silently skipped, no writes)
- MEMADR: src_a=10, src_b=01, alu_op=00. Next: MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- EXECR: src_a=10, src_b=00, alu_op=10. Next: ALUWB.
- EXECI: src_a=10, src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB.

PC write and cycle counts:
- pc_write = pc_update | (branch & taken).
- taken = zero for funct3 000; !zero for funct3 001 when SUPPORT_BNE=1.
- Cycles per instruction: lw 5, sw 4, R/I 4, branch 3, jal 4, illegal 2.

ALU decode (combinational):
- alu_op 00 -> add; alu_op 01 -> sub.
- alu_op 10, by funct3:
  - 000: sub if funct7b5 & op[5], else add
  - 010: slt
  - 110: or
  - 111: and
  - other: add

Immediate decode (combinational, by op):
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- else -> 00

Reset mid-instruction:
- Returns to FETCH immediately.
- No enable pulses on the cycle rst deasserts; the first FETCH enables fire on the following edge.

Decomposition:
- Package: state enum; opcode constants; alu_op, alu_control, result_src, src_a, src_b and imm_src encodings.
- Sub-module: alu_decoder (combinational: alu_op, funct3, funct7b5, op5 -> alu_control).

Test Plan:
- Reset: assert rst mid-MEMWB -> state FETCH, reg_write=0 immediately. Release rst -> ir_write=1, pc_write=1, src_b=10 in the first cycle.
- lw (op 0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. adr_src=1 in MEMREAD; reg_write=1 with result_src=01 only in the 5th cycle.
- R-type sub (op 0110011, funct3 000, funct7b5=1) -> alu_control=001 in EXECR. The same with funct7b5=0 -> 000. I-type addi with funct7b5=1 -> 000.
- beq with zero=1 -> pc_write=1 in BRANCH. zero=0 -> pc_write=0. bne (funct3 001) inverts this when SUPPORT_BNE=1.
- jal (op 1101111) -> DECODE, JAL (pc_write=1, src_a=01, src_b=10), ALUWB (reg_write=1), FETCH. imm_src=11 throughout.
- sw (op 0100011) -> mem_write=1 only in the 4th cycle, imm_src=01. Illegal op 0000000 -> DECODE returns to FETCH with no enables asserted.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package multicycle_controller_pkg;

   // Control FSM states; one per microstep of the multicycle datapath.
   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StJal
   } state_e;

   // Opcodes handled by the controller; anything else is skipped.
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   // Coarse ALU operation requested by the FSM, refined by the ALU decoder.
   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_e;

   // Operation code presented to the ALU.
   typedef enum logic [2:0] {
      AluAdd = 3'b000,
      AluSub = 3'b001,
      AluAnd = 3'b010,
      AluOr  = 3'b011,
      AluSlt = 3'b101
   } alu_ctrl_e;

   // Writeback / next-PC result mux.
   typedef enum logic [1:0] {
      ResAluOut  = 2'b00,
      ResMemData = 2'b01,
      ResAluLive = 2'b10
   } result_src_e;

   // ALU operand A mux.
   typedef enum logic [1:0] {
      SrcAPc    = 2'b00,
      SrcAOldPc = 2'b01,
      SrcARs1   = 2'b10
   } src_a_e;

   // ALU operand B mux.
   typedef enum logic [1:0] {
      SrcBRs2  = 2'b00,
      SrcBImm  = 2'b01,
      SrcBFour = 2'b10
   } src_b_e;

   // Immediate format selected for the extender.
   typedef enum logic [1:0] {
      ImmI = 2'b00,
      ImmS = 2'b01,
      ImmB = 2'b10,
      ImmJ = 2'b11
   } imm_src_e;

   // Immediate format depends only on the opcode, never on the state.
   function automatic imm_src_e imm_src_of(input logic [6:0] op);
      imm_src_e imm;
      case (op)
         OpStore:  imm = ImmS;
         OpBranch: imm = ImmB;
         OpJal:    imm = ImmJ;
         default:  imm = ImmI;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's coarse alu_op plus instruction fields into an ALU opcode.
module multicycle_controller_alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_control_o
);

   // Pure combinational decode; unsupported funct3 values fall back to add.
   always_comb begin
      alu_control_o = AluAdd;
      unique case (alu_op_i)
         AluOpAdd: alu_control_o = AluAdd;
         AluOpSub: alu_control_o = AluSub;
         AluOpFunct: begin
            unique case (funct3_i)
               // Only R-type (op[5]=1) may subtract; addi ignores instr[30].
               3'b000:  alu_control_o = (funct7b5_i & op5_i) ? AluSub : AluAdd;
               3'b010:  alu_control_o = AluSlt;
               3'b110:  alu_control_o = AluOr;
               3'b111:  alu_control_o = AluAnd;
               default: alu_control_o = AluAdd;
            endcase
         end
         default: alu_control_o = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback and drives every select and enable around it.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int unsigned SUPPORT_BNE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src
);

   state_e      state_q;

   alu_op_e     alu_op;
   result_src_e res_sel;
   src_a_e      src_a_sel;
   src_b_e      src_b_sel;
   logic        adr_sel;
   logic        pc_update;
   logic        branch;
   logic        taken;
   logic        ir_we;
   logic        mem_we;
   logic        reg_we;

   // State register and transition table; reset lands in FETCH immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         unique case (state_q)
            StFetch: state_q <= StDecode;
            StDecode: begin
               case (op)
                  OpLoad, OpStore: state_q <= StMemAdr;
                  OpRtype:         state_q <= StExecR;
                  OpItype:         state_q <= StExecI;
                  OpBranch:        state_q <= StBranch;
                  OpJal:           state_q <= StJal;
                  // Unknown opcodes are dropped without any write.
                  default:         state_q <= StFetch;
               endcase
            end
            StMemAdr:   state_q <= (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  state_q <= StMemWb;
            StMemWb:    state_q <= StFetch;
            StMemWrite: state_q <= StFetch;
            StExecR:    state_q <= StAluWb;
            StExecI:    state_q <= StAluWb;
            StAluWb:    state_q <= StFetch;
            StBranch:   state_q <= StFetch;
            StJal:      state_q <= StAluWb;
            default:    state_q <= StFetch;
         endcase
      end
   end

   // Per-state selects and raw enables; anything not set stays 00 / 0.
   always_comb begin
      alu_op    = AluOpAdd;
      res_sel   = ResAluOut;
      src_a_sel = SrcAPc;
      src_b_sel = SrcBRs2;
      adr_sel   = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_we     = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      unique case (state_q)
         StFetch: begin
            ir_we     = 1'b1;
            src_b_sel = SrcBFour;
            res_sel   = ResAluLive;
            pc_update = 1'b1;
         end
         StDecode: begin
            // Precompute the branch target into the ALU result register.
            src_a_sel = SrcAOldPc;
            src_b_sel = SrcBImm;
         end
         StMemAdr: begin
            src_a_sel = SrcARs1;
            src_b_sel = SrcBImm;
         end
         StMemRead: begin
            adr_sel = 1'b1;
         end
         StMemWb: begin
            res_sel = ResMemData;
            reg_we  = 1'b1;
         end
         StMemWrite: begin
            adr_sel = 1'b1;
            mem_we  = 1'b1;
         end
         StExecR: begin
            src_a_sel = SrcARs1;
            alu_op    = AluOpFunct;
         end
         StExecI: begin
            src_a_sel = SrcARs1;
            src_b_sel = SrcBImm;
            alu_op    = AluOpFunct;
         end
         StAluWb: begin
            reg_we = 1'b1;
         end
         StBranch: begin
            src_a_sel = SrcARs1;
            alu_op    = AluOpSub;
            branch    = 1'b1;
         end
         StJal: begin
            // Old PC + 4 is the link value; target was computed in DECODE.
            src_a_sel = SrcAOldPc;
            src_b_sel = SrcBFour;
            pc_update = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Branch condition: bne inverts zero when enabled, otherwise all branches are beq.
   always_comb begin
      taken = zero;
      if ((SUPPORT_BNE != 0) && (funct3 == 3'b001)) begin
         taken = ~zero;
      end
   end

   multicycle_controller_alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .op5_i         (op[5]),
      .alu_control_o (alu_control)
   );

   // Enables are masked by reset so nothing is written while rst is held.
   assign pc_write   = (pc_update | (branch & taken)) & ~rst;
   assign ir_write   = ir_we & ~rst;
   assign mem_write  = mem_we & ~rst;
   assign reg_write  = reg_we & ~rst;

   assign adr_src    = adr_sel;
   assign result_src = res_sel;
   assign alu_src_a  = src_a_sel;
   assign alu_src_b  = src_b_sel;
   assign imm_src    = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected per-cycle output vectors are
// queued when an instruction is driven and compared as the FSM steps through it.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [15:0] obs;

   int total = 0;
   int bad   = 0;
   string       tag_q[$];
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   multicycle_controller #(
      .SUPPORT_BNE (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .imm_src     (imm_src)
   );

   assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control, imm_src};

   // Vector layout: pcw adr mw irw rw | res | srcA | srcB | alu | imm
   function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw,
                                      input logic [1:0] res, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] alu,
                                      input logic [1:0] imm);
      return {pcw, adr, mw, irw, rw, res, sa, sb, alu, imm};
   endfunction

   function automatic logic [15:0] fetch_v(input logic [1:0] imm);
      return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm);
   endfunction

   function automatic logic [15:0] decode_v(input logic [1:0] imm);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm);
   endfunction

   function automatic logic [15:0] memadr_v(input logic [1:0] imm);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm);
   endfunction

   function automatic logic [15:0] aluwb_v(input logic [1:0] imm);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm);
   endfunction

   task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z);
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      zero     = z;
   endtask

   task automatic push(input string t, input logic [15:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   // Pop the next expectation and compare it against the live outputs.
   task automatic cmp();
      string       t;
      logic [15:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty got=%h exp=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", t, obs, e);
         end
      end
   endtask

   // Step n cycles, checking mid-cycle on the falling edge.
   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         cmp();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic alu_instr(input string t, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic [2:0] alu);
      logic [1:0] sb;
      sb = (o == OP_R) ? 2'b00 : 2'b01;
      drive(o, f3, f7, 1'b0);
      push({t, ".fetch"}, fetch_v(2'b00));
      push({t, ".decode"}, decode_v(2'b00));
      push({t, ".exec"}, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, alu, 2'b00));
      push({t, ".aluwb"}, aluwb_v(2'b00));
      run(4);
   endtask

   task automatic branch_instr(input string t, input logic [2:0] f3, input logic z,
                               input logic tk);
      drive(OP_BR, f3, 1'b0, z);
      push({t, ".fetch"}, fetch_v(2'b10));
      push({t, ".decode"}, decode_v(2'b10));
      push({t, ".branch"}, mk(tk, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10));
      run(3);
   endtask

   // Hard bound on run time so the bench never hangs.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      drive(OP_LW, 3'b010, 1'b0, 1'b0);
      #1;
      // In reset: FETCH selects, every enable held low.
      push("reset.hold", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
      cmp();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // lw: five cycles, memory data written back only in the last.
      drive(OP_LW, 3'b010, 1'b0, 1'b0);
      push("lw.fetch", fetch_v(2'b00));
      push("lw.decode", decode_v(2'b00));
      push("lw.memadr", memadr_v(2'b00));
      push("lw.memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
      push("lw.memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00));
      run(5);

      // ALU decode through R- and I-type execution.
      alu_instr("sub", OP_R, 3'b000, 1'b1, 3'b001);
      alu_instr("add", OP_R, 3'b000, 1'b0, 3'b000);
      alu_instr("addi_f7", OP_I, 3'b000, 1'b1, 3'b000);
      alu_instr("slt", OP_R, 3'b010, 1'b0, 3'b101);
      alu_instr("ori", OP_I, 3'b110, 1'b0, 3'b011);
      alu_instr("and", OP_R, 3'b111, 1'b1, 3'b010);
      alu_instr("xori_dflt", OP_I, 3'b100, 1'b0, 3'b000);

      // Branches: pc_write follows zero for beq, inverted for bne.
      branch_instr("beq_z1", 3'b000, 1'b1, 1'b1);
      branch_instr("beq_z0", 3'b000, 1'b0, 1'b0);
      branch_instr("bne_z0", 3'b001, 1'b0, 1'b1);
      branch_instr("bne_z1", 3'b001, 1'b1, 1'b0);

      // jal: link through ALUWB, J immediate throughout.
      drive(OP_JAL, 3'b000, 1'b0, 1'b0);
      push("jal.fetch", fetch_v(2'b11));
      push("jal.decode", decode_v(2'b11));
      push("jal.jal", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11));
      push("jal.aluwb", aluwb_v(2'b11));
      run(4);

      // sw: memory write only in the fourth cycle.
      drive(OP_SW, 3'b010, 1'b0, 1'b0);
      push("sw.fetch", fetch_v(2'b01));
      push("sw.decode", decode_v(2'b01));
      push("sw.memadr", memadr_v(2'b01));
      push("sw.memwrite", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01));
      run(4);

      // Illegal opcode: two cycles, no writes, then straight back to FETCH.
      drive(OP_BAD, 3'b000, 1'b0, 1'b1);
      push("bad.fetch", fetch_v(2'b00));
      push("bad.decode", decode_v(2'b00));
      run(2);

      // Reset asserted in the middle of MEMWB.
      drive(OP_LW, 3'b010, 1'b0, 1'b0);
      push("lw2.fetch", fetch_v(2'b00));
      push("lw2.decode", decode_v(2'b00));
      push("lw2.memadr", memadr_v(2'b00));
      push("lw2.memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
      run(4);
      push("lw2.memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00));
      @(negedge clk);
      cmp();
      #1;
      rst = 1'b1;
      #1;
      push("reset.midwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
      cmp();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First instruction after release starts with full FETCH enables.
      alu_instr("post_rst", OP_R, 3'b000, 1'b1, 3'b001);

      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
